ped_request_conditioner: RTL and testbench

Upstream input stage for the traffic-light controller. It conditions a raw board push-button (pedestrian request) into a clean, latched request. The chain is a two-flop synchroniser, then a debounce filter, then a rising-edge detector, then a request/acknowledge handshake with a post-service lockout timer. The traffic FSM samples `req`, pulses `ack` when it starts serving the request, and the block then ignores the button for a fixed lockout window.

---
 rtl/ped_request_conditioner.sv | 151 +++++++++++++++
 tb/tb_ped_request_conditioner.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_request_conditioner.sv
// ped_request_conditioner
//
// Conditions a raw, bouncing pedestrian push-button into a clean, latched
// request for the traffic-light controller. The chain is:
//   two-flop synchroniser -> debounce filter -> rising-edge detector ->
//   request/acknowledge handshake -> post-service lockout timer.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   btn_in       raw button input (asynchronous, bouncing)
//   ack          acknowledge from the traffic FSM (pulse or level)
//   btn_level    debounced button level, 1 = pressed
//   press_pulse  one-cycle pulse on each debounced press
//   req          latched pedestrian request (high while PENDING)
//   lockout      high while the post-service lockout timer runs
//   req_count    number of accepted requests, wraps at 256
module ped_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LOCKOUT_CYCLES  = 100000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       ack,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       req,
  output logic       lockout,
  output logic [7:0] req_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    LOCKOUT = 2'b10
  } state_t;

  // Electrical level of the button when it is not pressed.
  localparam logic        RELEASED_LEVEL = BTN_ACTIVE_LOW;
  localparam logic [31:0] DCNT_LAST      = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] LCNT_LAST      = 32'(LOCKOUT_CYCLES - 1);

  logic        sync1;
  logic        sync2;
  logic        pressed;
  logic [31:0] dcnt;
  logic [31:0] lcnt;
  state_t      state;

  // ---------------------------------------------------------------------------
  // Synchroniser. Reset loads the released level so that leaving reset with
  // the button up does not look like a press.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= RELEASED_LEVEL;
      sync2 <= RELEASED_LEVEL;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  // Normalise polarity: pressed = 1 whenever the button is held down.
  assign pressed = sync2 ^ RELEASED_LEVEL;

  // ---------------------------------------------------------------------------
  // Debounce filter and press edge detector.
  // dcnt counts consecutive cycles where the synchronised input disagrees with
  // the committed level; a single agreeing cycle restarts it. The same rule
  // governs press and release. press_pulse fires on the commit edge of a
  // 0->1 change only, so a held button yields a single pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dcnt        <= 32'd0;
      btn_level   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (pressed == btn_level) begin
        dcnt <= 32'd0;
      end else if (dcnt == DCNT_LAST) begin
        btn_level   <= pressed;
        dcnt        <= 32'd0;
        press_pulse <= pressed;
      end else begin
        dcnt <= dcnt + 32'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request / acknowledge / lockout FSM. req and lockout are registered
  // decodes updated alongside state so they switch on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lcnt      <= 32'd0;
      req_count <= 8'd0;
      req       <= 1'b0;
      lockout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // ack has no meaning until a request is outstanding.
          if (press_pulse) begin
            state     <= PENDING;
            req_count <= req_count + 8'd1;
            req       <= 1'b1;
            lockout   <= 1'b0;
          end
        end

        PENDING: begin
          // Extra presses while waiting for service are neither queued nor
          // counted.
          if (ack) begin
            state   <= LOCKOUT;
            lcnt    <= 32'd0;
            req     <= 1'b0;
            lockout <= 1'b1;
          end
        end

        LOCKOUT: begin
          // lcnt runs 0..LOCKOUT_CYCLES-1, giving exactly LOCKOUT_CYCLES
          // cycles of lockout after the ack edge. A press still held when the
          // timer expires needs a fresh debounced edge to be served.
          if (lcnt == LCNT_LAST) begin
            state   <= IDLE;
            lockout <= 1'b0;
          end else begin
            lcnt <= lcnt + 32'd1;
          end
        end

        default: begin
          // Unused encoding: recover to a quiet IDLE.
          state   <= IDLE;
          req     <= 1'b0;
          lockout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Bench for ped_request_conditioner with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8,
// active-low button. A behavioural model tracks the button history, the
// outstanding request and the cycle at which lockout ends.
module tb_ped_request_conditioner;

  localparam int D = 4;
  localparam int L = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_in;
  logic       ack;
  logic       btn_level;
  logic       press_pulse;
  logic       req;
  logic       lockout;
  logic [7:0] req_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  bit         dq[$];      // raw button samples still in flight to the filter
  bit         hist[$];    // last D pressed samples seen by the filter
  bit         m_level;
  bit         m_pulse;
  bit         m_pending;
  int         m_cyc;
  int         m_lock_end; // lockout is high after edge t iff t < m_lock_end
  logic [7:0] m_count;

  ped_request_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .LOCKOUT_CYCLES (L),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .ack        (ack),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .req        (req),
    .lockout    (lockout),
    .req_count  (req_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    dq = '{1'b1, 1'b1};
    hist.delete();
    m_level    = 1'b0;
    m_pulse    = 1'b0;
    m_pending  = 1'b0;
    m_cyc      = 0;
    m_lock_end = 0;
    m_count    = 8'd0;
  endtask

  // Advance the model by one clock edge using inputs present at that edge.
  task automatic model_edge();
    bit p;
    bit all_diff;
    m_cyc++;
    // Request handling sees the pulse produced on the previous edge.
    if (m_pending) begin
      if (ack) begin
        m_pending  = 1'b0;
        m_lock_end = m_cyc + L;
      end
    end else if (m_cyc > m_lock_end && m_pulse) begin
      m_pending = 1'b1;
      m_count   = m_count + 8'd1;
    end
    // Level commits once the last D samples all disagree with it.
    p = !dq[0];
    void'(dq.pop_front());
    dq.push_back(btn_in);
    hist.push_back(p);
    if (hist.size() > D) void'(hist.pop_front());
    m_pulse = 1'b0;
    if (hist.size() == D) begin
      all_diff = 1'b1;
      foreach (hist[i]) if (hist[i] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level = !m_level;
        m_pulse = m_level;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    btn_in = 1'b1;
    ack    = 1'b0;
    reset  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    btn_in = 1'b1;
    ack    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req !== 1'b0) begin bad++; $display("FAIL init_req: got %0b want 0", req); end
    total++; if (req_count !== 8'd0) begin bad++; $display("FAIL init_count: got %0d want 0", req_count); end
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL init_level: got %0b want 0", btn_level); end
    reset = 1'b0;
    model_reset();
    // Reach PENDING, then reset between edges.
    btn_in = 1'b0;
    repeat (8) tick();
    total++; if (req !== 1'b1) begin bad++; $display("FAIL pend_req: got %0b want 1", req); end
    total++; if (req_count !== 8'd1) begin bad++; $display("FAIL pend_count: got %0d want 1", req_count); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (req !== 1'b0) begin bad++; $display("FAIL async_req: got %0b want 0", req); end
    total++; if (lockout !== 1'b0) begin bad++; $display("FAIL async_lockout: got %0b want 0", lockout); end
    total++; if (btn_level !== 1'b0) begin bad++; $display("FAIL async_level: got %0b want 0", btn_level); end
    total++; if (press_pulse !== 1'b0) begin bad++; $display("FAIL async_pulse: got %0b want 0", press_pulse); end
    total++; if (req_count !== 8'd0) begin bad++; $display("FAIL async_count: got %0d want 0", req_count); end
    btn_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    repeat (3) tick();
    total++; if (req !== 1'b0 || lockout !== 1'b0) begin bad++; $display("FAIL post_reset_idle: got req=%0b lockout=%0b want 0 0", req, lockout); end
    $display("test_reset: req=%0b count=%0d", req, req_count);
  endtask

  task automatic test_clean_press();
    do_reset();
    btn_in = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      total++; if (btn_level !== (e >= 6)) begin bad++; $display("FAIL clean_level E%0d: got %0b want %0b", e, btn_level, (e >= 6)); end
      total++; if (press_pulse !== (e == 6)) begin bad++; $display("FAIL clean_pulse E%0d: got %0b want %0b", e, press_pulse, (e == 6)); end
      total++; if (req !== (e >= 7)) begin bad++; $display("FAIL clean_req E%0d: got %0b want %0b", e, req, (e >= 7)); end
    end
    total++; if (req_count !== 8'd1) begin bad++; $display("FAIL clean_count: got %0d want 1", req_count); end
    $display("test_clean_press: req=%0b count=%0d", req, req_count);
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      btn_in = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      total++; if (btn_level !== 1'b0 || press_pulse !== 1'b0 || req !== 1'b0) begin
        bad++; $display("FAIL bounce_%0d: got level=%0b pulse=%0b req=%0b want 0 0 0", i, btn_level, press_pulse, req);
      end
    end
    btn_in = 1'b1;
    repeat (10) tick();
    total++; if (req_count !== 8'd0) begin bad++; $display("FAIL bounce_count: got %0d want 0", req_count); end
    $display("test_bounce: level=%0b count=%0d", btn_level, req_count);
  endtask

  task automatic test_lockout();
    int pulses = 0;
    do_reset();
    btn_in = 1'b0;
    repeat (8) tick();
    btn_in = 1'b1;
    repeat (8) tick();
    total++; if (req !== 1'b1) begin bad++; $display("FAIL lock_pending: got %0b want 1", req); end
    ack = 1'b1;
    tick();                       // edge A
    ack    = 1'b0;
    btn_in = 1'b0;                // press during lockout
    total++; if (req !== 1'b0 || lockout !== 1'b1) begin bad++; $display("FAIL lock_A: got req=%0b lockout=%0b want 0 1", req, lockout); end
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (press_pulse) pulses++;
      total++; if (lockout !== 1'b1) begin bad++; $display("FAIL lock_A+%0d: got %0b want 1", k, lockout); end
    end
    tick();                       // A+8
    total++; if (lockout !== 1'b0) begin bad++; $display("FAIL lock_A+8: got %0b want 0", lockout); end
    total++; if (pulses != 1) begin bad++; $display("FAIL lock_press_seen: got %0d pulses want 1", pulses); end
    repeat (10) tick();           // button still held past lockout
    total++; if (req !== 1'b0) begin bad++; $display("FAIL lock_held_req: got %0b want 0", req); end
    total++; if (req_count !== 8'd1) begin bad++; $display("FAIL lock_count: got %0d want 1", req_count); end
    btn_in = 1'b1;
    repeat (8) tick();
    $display("test_lockout: req=%0b lockout=%0b count=%0d", req, lockout, req_count);
  endtask

  task automatic test_ack_hold();
    int pulses = 0;
    do_reset();
    repeat (3) begin
      ack = 1'b1; tick();
      ack = 1'b0; tick();
    end
    total++; if (req !== 1'b0 || lockout !== 1'b0) begin bad++; $display("FAIL idle_ack: got req=%0b lockout=%0b want 0 0", req, lockout); end
    btn_in = 1'b0;
    repeat (100) begin
      tick();
      if (press_pulse) pulses++;
    end
    total++; if (pulses != 1) begin bad++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    total++; if (req !== 1'b1 || req_count !== 8'd1) begin bad++; $display("FAIL hold_req: got req=%0b count=%0d want 1 1", req, req_count); end
    btn_in = 1'b1;
    repeat (10) tick();
    ack = 1'b1;
    repeat (3) tick();            // level ack, accepted once
    ack = 1'b0;
    repeat (L) tick();
    total++; if (lockout !== 1'b0 || req !== 1'b0) begin bad++; $display("FAIL ack_level_end: got lockout=%0b req=%0b want 0 0", lockout, req); end
    btn_in = 1'b0;
    repeat (8) tick();
    total++; if (req_count !== 8'd2 || req !== 1'b1) begin bad++; $display("FAIL second_press: got count=%0d req=%0b want 2 1", req_count, req); end
    btn_in = 1'b1;
    repeat (8) tick();
    $display("test_ack_hold: pulses=%0d count=%0d", pulses, req_count);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int n = 1; n <= 257; n++) begin
      btn_in = 1'b0; repeat (8) tick();
      btn_in = 1'b1; repeat (7) tick();
      ack = 1'b1; tick();
      ack = 1'b0; repeat (L + 1) tick();
      total++; if (req_count !== m_count) begin bad++; $display("FAIL wrap_iter%0d: got %0d want %0d", n, req_count, m_count); end
      if (n == 256) begin
        total++; if (req_count !== 8'd0) begin bad++; $display("FAIL wrap_256: got %0d want 0", req_count); end
      end
      if (n == 257) begin
        total++; if (req_count !== 8'd1) begin bad++; $display("FAIL wrap_257: got %0d want 1", req_count); end
      end
    end
    $display("test_wrap: count=%0d", req_count);
  endtask

  task automatic test_random();
    int run = 0;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (run == 0) begin
        btn_in = 1'($urandom_range(0, 1));
        run    = $urandom_range(1, 9);
      end
      run--;
      ack = ($urandom_range(0, 3) == 0);
      tick();
      total++; if (btn_level !== m_level) begin bad++; $display("FAIL rnd_level c%0d: got %0b want %0b", c, btn_level, m_level); end
      total++; if (press_pulse !== m_pulse) begin bad++; $display("FAIL rnd_pulse c%0d: got %0b want %0b", c, press_pulse, m_pulse); end
      total++; if (req !== m_pending) begin bad++; $display("FAIL rnd_req c%0d: got %0b want %0b", c, req, m_pending); end
      total++; if (lockout !== (m_cyc < m_lock_end)) begin bad++; $display("FAIL rnd_lockout c%0d: got %0b want %0b", c, lockout, (m_cyc < m_lock_end)); end
      total++; if (req_count !== m_count) begin bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, req_count, m_count); end
    end
    ack = 1'b0;
    $display("test_random: count=%0d", req_count);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_lockout();
    test_ack_hold();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
